spike_rate_encoder: RTL and testbench

Sequential rate encoder that converts an N-bit weighted sum, such as the output of the neuron input adder tree, back into a spike train. It uses first-order sigma-delta accumulation, so a value V produces exactly V spikes across a fixed window of 2^N_BITS cycles. It is the inverse direction of the spike-weighting/summing path and is used to drive synthetic spike inputs and to loop sums back into neuron arrays. A valid/ready input handshake accepts one value per window.

---
 rtl/spike_rate_encoder_if.sv | 23 ++
 rtl/spike_rate_encoder.sv | 122 ++++++++++++
 tb/tb_spike_rate_encoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spike_rate_encoder_if.sv
// Handshake and spike-train bundle for spike_rate_encoder.
// The master side presents values; the slave side is the encoder.
interface spike_rate_encoder_if #(
   parameter int unsigned N_BITS = 7
);
   logic              in_valid;
   logic [N_BITS-1:0] in_value;
   logic              in_ready;
   logic              spike_out;
   logic              busy;
   logic              done;
   logic [N_BITS-1:0] spike_count;

   modport master (
      output in_valid, in_value,
      input  in_ready, spike_out, busy, done, spike_count
   );

   modport slave (
      input  in_valid, in_value,
      output in_ready, spike_out, busy, done, spike_count
   );
endinterface

// File: rtl/spike_rate_encoder.sv
// First-order sigma-delta rate encoder: value V yields V spikes over 2^N_BITS cycles.
// Define SPIKE_ENCODER_COUNT_EN to build the per-window spike counter (else spike_count is 0).
module spike_rate_encoder #(
   parameter int unsigned N_BITS = 7
) (
   input logic                clk,
   input logic                reset,
   spike_rate_encoder_if.slave enc
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [N_BITS-1:0] acc_q, acc_d;
   logic [N_BITS-1:0] value_q, value_d;
   logic [N_BITS-1:0] cycle_q, cycle_d;
   logic              spike_q, spike_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic [N_BITS:0]   sum;
`ifdef SPIKE_ENCODER_COUNT_EN
   logic [N_BITS-1:0] count_q, count_d;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      value_d = value_q;
      cycle_d = cycle_q;
      spike_d = spike_q;
      done_d  = done_q;
      ready_d = ready_q;
      busy_d  = busy_q;
`ifdef SPIKE_ENCODER_COUNT_EN
      count_d = count_q;
`endif
      sum = {1'b0, acc_q} + {1'b0, value_q};

      case (state_q)
         IDLE: begin
            if (enc.in_valid && ready_q) begin
               state_d = RUN;
               value_d = enc.in_value;
               acc_d   = '0;
               cycle_d = '0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
`ifdef SPIKE_ENCODER_COUNT_EN
               count_d = '0;
`endif
            end
         end
         RUN: begin
            acc_d   = sum[N_BITS-1:0];
            spike_d = sum[N_BITS];
            cycle_d = cycle_q + 1'b1;
`ifdef SPIKE_ENCODER_COUNT_EN
            count_d = count_q + {{(N_BITS-1){1'b0}}, sum[N_BITS]};
`endif
            // cycle_q all-ones marks the 2^N_BITS-th accumulation
            if (cycle_q == '1) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            spike_d = 1'b0;
            done_d  = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            spike_d = 1'b0;
            done_d  = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         value_q <= '0;
         cycle_q <= '0;
         spike_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
`ifdef SPIKE_ENCODER_COUNT_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         cycle_q <= cycle_d;
         spike_q <= spike_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
`ifdef SPIKE_ENCODER_COUNT_EN
         count_q <= count_d;
`endif
      end
   end

   assign enc.in_ready  = ready_q;
   assign enc.spike_out = spike_q;
   assign enc.busy      = busy_q;
   assign enc.done      = done_q;
`ifdef SPIKE_ENCODER_COUNT_EN
   assign enc.spike_count = count_q;
`else
   assign enc.spike_count = '0;
`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: spike patterns, done timing, handshake and reset.
module tb_spike_rate_encoder;

   localparam int unsigned N = 7;
   localparam int W = 1 << N;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cyc;
   int   prev_acc;

   spike_rate_encoder_if #(.N_BITS(N)) enc_if ();

   spike_rate_encoder #(.N_BITS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .enc   (enc_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(enc_if.in_ready), 32'd1);
      chk({tag, "_spike"}, 32'(enc_if.spike_out), 32'd0);
      chk({tag, "_busy"},  32'(enc_if.busy), 32'd0);
      chk({tag, "_done"},  32'(enc_if.done), 32'd0);
      chk({tag, "_count"}, 32'(enc_if.spike_count), 32'd0);
   endtask

   function automatic int exp_spike(input int v, input int k);
      return ((k * v) / W) - (((k - 1) * v) / W);
   endfunction

   function automatic int exp_count(input int v);
`ifdef SPIKE_ENCODER_COUNT_EN
      return v;
`else
      return 0;
`endif
   endfunction

   // Entered at a negedge; leaves at the negedge after E(W+1).
   task automatic run_window(input int v, input bit hold, input int hold_val);
      int seen;
      seen = 0;
      enc_if.in_valid = 1'b1;
      enc_if.in_value = N'(v);
      chk("pre_accept_ready", 32'(enc_if.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (hold) enc_if.in_value = N'(hold_val);
      else enc_if.in_valid = 1'b0;
      chk("w0_busy", 32'(enc_if.busy), 32'd1);
      chk("w0_ready", 32'(enc_if.in_ready), 32'd0);
      chk("w0_spike", 32'(enc_if.spike_out), 32'd0);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d_spike_k%0d", v, k), 32'(enc_if.spike_out), 32'(exp_spike(v, k)));
         chk($sformatf("v%0d_done_k%0d", v, k), 32'(enc_if.done), 32'(k == W));
         chk($sformatf("v%0d_busy_k%0d", v, k), 32'(enc_if.busy), 32'd1);
         chk($sformatf("v%0d_ready_k%0d", v, k), 32'(enc_if.in_ready), 32'd0);
         seen += int'(enc_if.spike_out);
      end
      chk($sformatf("v%0d_total_spikes", v), 32'(seen), 32'(v));
      chk($sformatf("v%0d_count_at_done", v), 32'(enc_if.spike_count), 32'(exp_count(v)));
      @(negedge clk);
      chk("post_ready", 32'(enc_if.in_ready), 32'd1);
      chk("post_busy", 32'(enc_if.busy), 32'd0);
      chk("post_done", 32'(enc_if.done), 32'd0);
      chk("post_spike", 32'(enc_if.spike_out), 32'd0);
      chk("post_count_hold", 32'(enc_if.spike_count), 32'(exp_count(v)));
   endtask

   initial begin
      reset = 1'b1;
      enc_if.in_valid = 1'b0;
      enc_if.in_value = '0;
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("idle");

      run_window(0, 1'b0, 0);
      run_window(1, 1'b0, 0);
      run_window(64, 1'b0, 0);
      run_window(127, 1'b0, 0);

      // Second value held during RUN is accepted at the earliest legal edge.
      run_window(96, 1'b1, 5);
      prev_acc = acc_cyc;
      run_window(5, 1'b0, 0);
      chk("accept_period", 32'(acc_cyc - prev_acc), 32'(W + 2));

      // Reset in window cycle 40 of value 100.
      enc_if.in_valid = 1'b1;
      enc_if.in_value = N'(100);
      @(posedge clk);
      @(negedge clk);
      enc_if.in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         chk($sformatf("r100_spike_k%0d", k), 32'(enc_if.spike_out), 32'(exp_spike(100, k)));
      end
      chk("r100_busy", 32'(enc_if.busy), 32'd1);
      #1 reset = 1'b1;
      #1 chk_reset_vals("midrst");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_reset_vals("midrst_hold");
      end
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_reset_vals("after_rst_idle");
      end
      run_window(3, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
